// File: rtl/au16_arbiter_if.sv
// Bundle of the two requester channels, the shared AU drive/return and the response channel.
// The arbiter connects through the slave modport; its environment uses master.
interface au16_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             au_op_sel;
    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic [WIDTH-1:0] au_res;
    logic             au_v;
    logic             au_c;
    logic             au_n;
    logic             au_z;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_res;
    logic [3:0]       rsp_flags;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  au_res, au_v, au_c, au_n, au_z,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output au_op_sel, au_a, au_b,
        output rsp_valid, rsp_id, rsp_res, rsp_flags
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output au_res, au_v, au_c, au_n, au_z,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  au_op_sel, au_a, au_b,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags
    );
endinterface

// File: rtl/au16_arbiter.sv
// Round-robin arbiter sharing one combinational add/subtract unit between two requesters,
// one operation in flight: accept (IDLE), capture AU result (EXEC), hold response (RESP).
module au16_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    au16_arbiter_if.slave      bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             au_op_sel_q,  au_op_sel_d;
    logic [WIDTH-1:0] au_a_q,       au_a_d;
    logic [WIDTH-1:0] au_b_q,       au_b_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_res_q,    rsp_res_d;
    logic [3:0]       rsp_flags_q,  rsp_flags_d;

    logic             any_valid;
    logic             grant;
    logic             req0_ready;
    logic             req1_ready;

    // On a tie the requester that did not win last time goes first.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        au_op_sel_d  = au_op_sel_q;
        au_a_d       = au_a_q;
        au_b_d       = au_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_flags_d  = rsp_flags_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    req0_ready   = ~grant;
                    req1_ready   = grant;
                    au_op_sel_d  = grant ? bus.req1_op : bus.req0_op;
                    au_a_d       = grant ? bus.req1_a  : bus.req0_a;
                    au_b_d       = grant ? bus.req1_b  : bus.req0_b;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_res_d   = bus.au_res;
                rsp_flags_d = {bus.au_v, bus.au_c, bus.au_n, bus.au_z};
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            au_op_sel_q  <= 1'b0;
            au_a_q       <= '0;
            au_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_flags_q  <= 4'b0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            au_op_sel_q  <= au_op_sel_d;
            au_a_q       <= au_a_d;
            au_b_q       <= au_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.au_op_sel  = au_op_sel_q;
    assign bus.au_a       = au_a_q;
    assign bus.au_b       = au_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_res    = rsp_res_q;
    assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_au16_arbiter.sv
// Bench for au16_arbiter: a golden AU answers the registered operands, directed scenarios
// are followed by a randomized run checked against a transaction-level queue model.
module tb_au16_arbiter;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    au16_arbiter_if #(.WIDTH(WIDTH)) bus ();

    au16_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Returns {v, c, n, z, res}; c is the carry out for add and the borrow for subtract.
    function automatic logic [19:0] golden(input logic op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] full;
        logic [15:0] r;
        logic        v;
        full = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        r    = full[15:0];
        v    = op ? ((a[15] != b[15]) && (r[15] != a[15]))
                  : ((a[15] == b[15]) && (r[15] != a[15]));
        return {v, full[16], r[15], (r == 16'h0000), r};
    endfunction

    logic [19:0] au_gold;
    assign au_gold    = golden(bus.au_op_sel, bus.au_a, bus.au_b);
    assign bus.au_res = au_gold[15:0];
    assign bus.au_v   = au_gold[19];
    assign bus.au_c   = au_gold[18];
    assign bus.au_n   = au_gold[17];
    assign bus.au_z   = au_gold[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Presents one op on one requester until accepted; returns just after the accept edge.
    task automatic issue(input logic id, input logic op, input logic [15:0] a, input logic [15:0] b);
        bit got;
        got = 1'b0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("issue_accept", got, 1);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check("rsp_timeout", ok, 1);
    endtask

    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic [3:0]  flags;
        int          visible_at;
    } exp_rsp_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_id[$];
        int          acc_cyc[$];
        int          n0;
        int          n1;
        bit          seen;
        exp_rsp_t    model_q[$];
        exp_rsp_t    e;
        logic        last_win;
        logic        v0, v1, w, free_now, accept, exp_rv;
        logic [19:0] g;

        // Reset state.
        do_reset();
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id",    bus.rsp_id,    0);
        check("rst_rsp_res",   bus.rsp_res,   0);
        check("rst_rsp_flags", bus.rsp_flags, 0);
        check("rst_au_op_sel", bus.au_op_sel, 0);
        check("rst_au_a",      bus.au_a,      0);
        check("rst_au_b",      bus.au_b,      0);
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);

        // Scenario 1: req0 add 3+5 with cycle-exact timing.
        cyc();
        bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_a = 16'h0003; bus.req0_b = 16'h0005;
        @(negedge clk);
        check("t1_ready0", bus.req0_ready, 1);
        check("t1_ready1", bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        check("t1_exec_rsp_valid", bus.rsp_valid, 0);
        check("t1_au_a", bus.au_a, 16'h0003);
        check("t1_au_b", bus.au_b, 16'h0005);
        check("t1_au_op_sel", bus.au_op_sel, 0);
        cyc();
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_rsp_id",    bus.rsp_id,    0);
        check("t1_rsp_res",   bus.rsp_res,   16'h0008);
        check("t1_rsp_flags", bus.rsp_flags, 4'b0000);
        rsp_handshake();
        check("t1_rsp_dropped", bus.rsp_valid, 0);

        // Scenario 2: zero result from req1, then signed overflow from req0.
        issue(1'b1, 1'b1, 16'h0005, 16'h0005);
        wait_rsp();
        check("t2a_rsp_id",    bus.rsp_id,       1);
        check("t2a_rsp_res",   bus.rsp_res,      16'h0000);
        check("t2a_z",         bus.rsp_flags[0], 1);
        check("t2a_rsp_flags", bus.rsp_flags,    4'b0001);
        rsp_handshake();
        issue(1'b0, 1'b0, 16'h7FFF, 16'h0001);
        wait_rsp();
        check("t2b_rsp_id",    bus.rsp_id,       0);
        check("t2b_rsp_res",   bus.rsp_res,      16'h8000);
        check("t2b_v",         bus.rsp_flags[3], 1);
        check("t2b_n",         bus.rsp_flags[1], 1);
        check("t2b_rsp_flags", bus.rsp_flags,    4'b1010);
        rsp_handshake();

        // Scenario 3: both requesters valid continuously, consumer always ready.
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_a = 16'h0009; bus.req1_b = 16'h0004;
        seen = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) seen = 1'b1;
            if (bus.req0_ready === 1'b1) begin acc_id.push_back(0); acc_cyc.push_back(c); end
            if (bus.req1_ready === 1'b1) begin acc_id.push_back(1); acc_cyc.push_back(c); end
        end
        check("t3_both_ready", seen, 0);
        check("t3_accept_count_ge4", (acc_id.size() >= 4), 1);
        for (int i = 0; i < acc_id.size() && i < 4; i++) begin
            check($sformatf("t3_grant%0d", i), acc_id[i], i % 2);
            if (i > 0) check($sformatf("t3_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
        end

        // Scenario 4: consumer stalls five cycles in RESP.
        do_reset();
        issue(1'b0, 1'b1, 16'h1234, 16'h0034);
        wait_rsp();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_ready0_c%0d", i), bus.req0_ready, 0);
            check($sformatf("t4_ready1_c%0d", i), bus.req1_ready, 0);
            check($sformatf("t4_rsp_valid_c%0d", i), bus.rsp_valid, 1);
            check($sformatf("t4_rsp_res_c%0d", i), bus.rsp_res, 16'h1200);
            check($sformatf("t4_rsp_id_c%0d", i), bus.rsp_id, 0);
            check($sformatf("t4_rsp_flags_c%0d", i), bus.rsp_flags, 4'b0000);
            check($sformatf("t4_au_a_c%0d", i), bus.au_a, 16'h1234);
            check($sformatf("t4_au_b_c%0d", i), bus.au_b, 16'h0034);
            check($sformatf("t4_au_op_c%0d", i), bus.au_op_sel, 1);
        end
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        check("t4_rsp_released", bus.rsp_valid, 0);
        @(negedge clk);
        check("t4_idle_ready1", bus.req1_ready, 1);
        check("t4_idle_ready0", bus.req0_ready, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Scenario 5: only req1 valid; it wins every IDLE cycle.
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_op = 1'b0; bus.req1_a = 16'h0002; bus.req1_b = 16'h0003;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req0_ready === 1'b1) n0++;
            if (bus.req1_ready === 1'b1) n1++;
        end
        check("t5_req1_grants", n1, 4);
        check("t5_req0_grants", n0, 0);

        // Scenario 6: reset while an op is executing.
        do_reset();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 1'b0, 16'hAAAA, 16'h5555);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rsp_valid", bus.rsp_valid, 0);
        check("t6_rsp_res",   bus.rsp_res,   0);
        check("t6_rsp_flags", bus.rsp_flags, 0);
        check("t6_rsp_id",    bus.rsp_id,    0);
        check("t6_au_a",      bus.au_a,      0);
        check("t6_au_b",      bus.au_b,      0);
        check("t6_au_op_sel", bus.au_op_sel, 0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        check("t6_no_response", seen, 0);

        // Randomized run against a queue of expected responses.
        do_reset();
        last_win = 1'b1;
        for (int t = 0; t < 600; t++) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req0_op    = $urandom_range(0, 1);
            bus.req1_op    = $urandom_range(0, 1);
            bus.req0_a     = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom());
            bus.req0_b     = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom());
            bus.req1_a     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
            bus.req1_b     = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom());
            bus.rsp_ready  = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            v0       = bus.req0_valid;
            v1       = bus.req1_valid;
            free_now = (model_q.size() == 0);
            w        = (v0 && v1) ? ~last_win : v1;
            accept   = free_now && (v0 || v1);
            exp_rv   = (model_q.size() > 0) && (t >= model_q[0].visible_at);
            check("rnd_ready0", bus.req0_ready, accept && !w);
            check("rnd_ready1", bus.req1_ready, accept && w);
            check("rnd_rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv) begin
                check("rnd_rsp_id",    bus.rsp_id,    model_q[0].id);
                check("rnd_rsp_res",   bus.rsp_res,   model_q[0].res);
                check("rnd_rsp_flags", bus.rsp_flags, model_q[0].flags);
            end
            if (accept) begin
                g            = w ? golden(bus.req1_op, bus.req1_a, bus.req1_b)
                                 : golden(bus.req0_op, bus.req0_a, bus.req0_b);
                e.id         = w;
                e.res        = g[15:0];
                e.flags      = g[19:16];
                e.visible_at = t + 2;
                model_q.push_back(e);
                last_win     = w;
            end else if (exp_rv && bus.rsp_ready) begin
                void'(model_q.pop_front());
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
